// File: rtl/ahb_stream_loader.sv
// ahb_stream_loader
//   AHB-Lite master that boot-loads a program image into on-chip memory. It
//   takes a byte stream over a valid/ready handshake, packs four bytes per
//   word little-endian and writes NWORDS words to consecutive word addresses
//   from BASE_ADDR. Each word goes out as a single NONSEQ WORD write, and at
//   most one transfer is outstanding at any time.
//
// Optional feature macro: LOADER_READBACK_EN
//   When defined, every write is followed by a NONSEQ read of the same address.
//   The returned data is compared with the word just written, and any mismatch
//   sets the sticky verify_err flag. When not defined, verify_err is tied to 0
//   and HRDATA is ignored.
//
// Parameters
//   BASE_ADDR  byte address of the first word (low 2 bits must be 0)
//   NWORDS     words per load, 1..2^20
//
// Ports
//   HCLK        in   system clock, rising edge
//   HRESET      in   asynchronous active-high reset
//   start       in   1-cycle pulse that starts a load (only honoured in IDLE)
//   s_data      in   stream byte
//   s_valid     in   stream byte valid
//   s_ready     out  high only while collecting bytes for a word
//   HADDR       out  AHB address
//   HTRANS      out  IDLE (2'b00) or NONSEQ (2'b10)
//   HWRITE      out  1 = write
//   HSIZE       out  fixed WORD (3'b010)
//   HWDATA      out  write data, valid in the write data phase
//   HREADY      in   bus ready; a low value stretches the current phase
//   HRDATA      in   read data (used only with readback)
//   busy        out  high from the cycle after an accepted start until done
//   done        out  1-cycle pulse after the last word completes
//   verify_err  out  sticky readback mismatch flag

module ahb_stream_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NWORDS    = 1024
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  output logic        busy,
  output logic        done,
  output logic        verify_err
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Wide enough to hold NWORDS itself (up to 2^20).
  localparam int CNT_W = $clog2(NWORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WADDR,
    S_WDATA,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t             state_reg;
  state_t             state_next;

  logic [31:0]        addr_reg;
  logic [CNT_W-1:0]   word_cnt_reg;
  logic [1:0]         byte_idx_reg;
  logic [31:0]        word_reg;

  logic               start_take;
  logic               byte_take;
  logic               word_done;
  logic               word_last;

  assign start_take = (state_reg == S_IDLE) && start;
  assign byte_take  = (state_reg == S_FILL) && s_valid;
  assign word_last  = (word_cnt_reg == LAST_CNT);

  // The address register doubles as HADDR. It only changes between transfers,
  // so the address stays stable through any wait states.
  assign HADDR = addr_reg;
  assign HSIZE = 3'b010;
  assign busy  = (state_reg != S_IDLE);

  // --------------------------------------------------------------------------
  // State register. Because the reset is asynchronous, HTRANS (which is
  // decoded from the state) drops to IDLE as soon as HRESET rises.
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and bus/handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    HTRANS     = TRANS_IDLE;
    HWRITE     = 1'b0;
    HWDATA     = '0;
    done       = 1'b0;
    word_done  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FILL;
        end
      end

      S_FILL: begin
        s_ready = 1'b1;
        if (s_valid && (byte_idx_reg == 2'd3)) begin
          state_next = S_WADDR;
        end
      end

      S_WADDR: begin
        HTRANS = TRANS_NONSEQ;
        HWRITE = 1'b1;
        if (HREADY) begin
          state_next = S_WDATA;
        end
      end

      S_WDATA: begin
        HWDATA = word_reg;
        if (HREADY) begin
`ifdef LOADER_READBACK_EN
          state_next = S_RADDR;
`else
          word_done  = 1'b1;
          state_next = word_last ? S_DONE : S_FILL;
`endif
        end
      end

`ifdef LOADER_READBACK_EN
      S_RADDR: begin
        HTRANS = TRANS_NONSEQ;
        if (HREADY) begin
          state_next = S_RDATA;
        end
      end

      S_RDATA: begin
        if (HREADY) begin
          word_done  = 1'b1;
          state_next = word_last ? S_DONE : S_FILL;
        end
      end
`endif

      S_DONE: begin
        // start is deliberately not examined here; a new load needs IDLE.
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address, word counter, and byte packing
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_reg     <= '0;
      word_cnt_reg <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
    end else begin
      if (start_take) begin
        addr_reg     <= BASE_ADDR;
        word_cnt_reg <= '0;
        byte_idx_reg <= '0;
        word_reg     <= '0;
      end
      if (byte_take) begin
        // Little-endian packing: the first byte lands in bits [7:0].
        word_reg[{byte_idx_reg, 3'b000} +: 8] <= s_data;
        byte_idx_reg                         <= byte_idx_reg + 2'd1;
      end
      if (word_done) begin
        // 32-bit wrap past 32'hFFFF_FFFC is intentional.
        addr_reg     <= addr_reg + 32'd4;
        word_cnt_reg <= word_cnt_reg + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Readback verification
  // --------------------------------------------------------------------------
`ifdef LOADER_READBACK_EN
  logic verify_err_reg;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      verify_err_reg <= 1'b0;
    end else if (start_take) begin
      verify_err_reg <= 1'b0;
    end else if ((state_reg == S_RDATA) && HREADY && (HRDATA != word_reg)) begin
      verify_err_reg <= 1'b1;
    end
  end

  assign verify_err = verify_err_reg;
`else
  logic unused_hrdata;
  assign unused_hrdata = ^HRDATA;
  assign verify_err    = 1'b0;
`endif

endmodule
